// File: rtl/adder_axis_stim_if.sv
// AXI-Stream channel bundle for the adder stimulus block: data, valid and ready.
// W is the tdata width; the master drives tdata/tvalid, the slave drives tready.
interface adder_axis_stim_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adder_axis_stim.sv
// Self-test source/sink for the two-operand AXIS adder: streams a deterministic operand
// sequence, checks every returned sum and counts transactions and mismatches.
module adder_axis_stim #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TXN    = 16,
    parameter int OP1_INIT   = 0,
    parameter int OP2_INIT   = 0,
    parameter int OP1_STEP   = 1,
    parameter int OP2_STEP   = 3
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    adder_axis_stim_if.master data1_o,
    adder_axis_stim_if.master data2_o,
    adder_axis_stim_if.slave  sum_i,
    output logic              busy,
    output logic              done,
    output logic [15:0]       txn_cnt,
    output logic [15:0]       err_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DATA_WIDTH-1:0] OP1_I = DATA_WIDTH'(OP1_INIT);
    localparam logic [DATA_WIDTH-1:0] OP2_I = DATA_WIDTH'(OP2_INIT);
    localparam logic [DATA_WIDTH-1:0] OP1_S = DATA_WIDTH'(OP1_STEP);
    localparam logic [DATA_WIDTH-1:0] OP2_S = DATA_WIDTH'(OP2_STEP);
    localparam logic [15:0]           NTXN  = 16'(NUM_TXN);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic                  sent1_q, sent1_d, sent2_q, sent2_d;
    logic [15:0]           txn_q, txn_d, err_q, err_d;
    logic                  busy_q, busy_d, done_q, done_d;

    logic                  hs1, hs2, both_sent;
    logic [DATA_WIDTH:0]   exp_sum;
    logic [15:0]           txn_inc;

    // valid comes only from state, never from tready
    assign data1_o.tdata  = op1_q;
    assign data2_o.tdata  = op2_q;
    assign data1_o.tvalid = (state_q == S_SEND) && !sent1_q;
    assign data2_o.tvalid = (state_q == S_SEND) && !sent2_q;
    assign sum_i.tready   = (state_q == S_WAIT);

    assign hs1       = data1_o.tvalid && data1_o.tready;
    assign hs2       = data2_o.tvalid && data2_o.tready;
    assign both_sent = (sent1_q || hs1) && (sent2_q || hs2);
    assign exp_sum   = {1'b0, op1_q} + {1'b0, op2_q};
    assign txn_inc   = txn_q + 16'd1;

    assign busy    = busy_q;
    assign done    = done_q;
    assign txn_cnt = txn_q;
    assign err_cnt = err_q;

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sent1_d = sent1_q;
        sent2_d = sent2_q;
        txn_d   = txn_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SEND;
                    op1_d   = OP1_I;
                    op2_d   = OP2_I;
                    sent1_d = 1'b0;
                    sent2_d = 1'b0;
                    txn_d   = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (both_sent) begin
                    state_d = S_WAIT;
                    sent1_d = 1'b0;
                    sent2_d = 1'b0;
                end else begin
                    sent1_d = sent1_q || hs1;
                    sent2_d = sent2_q || hs2;
                end
            end
            S_WAIT: begin
                if (sum_i.tvalid) begin
                    txn_d = txn_inc;
                    if (sum_i.tdata != exp_sum && err_q != 16'hFFFF)
                        err_d = err_q + 16'd1;
                    if (txn_inc == NTXN) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        op1_d   = op1_q + OP1_S;
                        op2_d   = op2_q + OP2_S;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            op1_q   <= OP1_I;
            op2_q   <= OP2_I;
            sent1_q <= 1'b0;
            sent2_q <= 1'b0;
            txn_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sent1_q <= sent1_d;
            sent2_q <= sent2_d;
            txn_q   <= txn_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_adder_axis_stim.sv
// Bench for adder_axis_stim: behavioural adder sinks with random backpressure phases,
// operand sequences checked against closed-form init + k*step references.
module tb_adder_axis_stim;
    localparam int DW = 8, N = 16, S1 = 1, S2 = 3;
    localparam int WN = 8, WI1 = 250, WI2 = 10;

    logic aclk = 1'b0, aresetn = 1'b1, start = 1'b0;
    logic busy, done, w_busy, w_done;
    logic [15:0] txn_cnt, err_cnt, w_txn, w_err;

    adder_axis_stim_if #(.W(DW))   d1(), d2(), w_d1(), w_d2();
    adder_axis_stim_if #(.W(DW+1)) s(), w_s();

    always #5 aclk = ~aclk;

    adder_axis_stim #(.DATA_WIDTH(DW), .NUM_TXN(N), .OP1_INIT(0), .OP2_INIT(0),
                      .OP1_STEP(S1), .OP2_STEP(S2)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .data1_o(d1), .data2_o(d2), .sum_i(s),
        .busy(busy), .done(done), .txn_cnt(txn_cnt), .err_cnt(err_cnt));

    adder_axis_stim #(.DATA_WIDTH(DW), .NUM_TXN(WN), .OP1_INIT(WI1), .OP2_INIT(WI2),
                      .OP1_STEP(S1), .OP2_STEP(S2)) u_wrap (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .data1_o(w_d1), .data2_o(w_d2), .sum_i(w_s),
        .busy(w_busy), .done(w_done), .txn_cnt(w_txn), .err_cnt(w_err));

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] opref(input int init, input int step, input int k);
        return DW'((init + k * step) % 256);
    endfunction

    // ---------------- main adder model + monitor ----------------
    logic [DW-1:0] q1[$], q2[$];
    logic [DW-1:0] a1, a2, pd1, pd2;
    logic          got1 = 0, got2 = 0, s_pend = 0, pv1 = 0, pv2 = 0;
    logic [DW:0]   s_val = '0;
    int            nres = 0, stab_bad = 0;
    bit            inj_en = 0, spur = 0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q1.delete(); q2.delete();
            got1 = 0; got2 = 0; s_pend = 0; nres = 0; pv1 = 0; pv2 = 0;
        end else begin
            if (start && !busy) begin
                q1.delete(); q2.delete(); nres = 0;
            end
            // a pending valid must hold both tvalid and tdata
            if (pv1 && (!d1.tvalid || d1.tdata !== pd1)) stab_bad++;
            if (pv2 && (!d2.tvalid || d2.tdata !== pd2)) stab_bad++;
            pv1 = d1.tvalid && !d1.tready; pd1 = d1.tdata;
            pv2 = d2.tvalid && !d2.tready; pd2 = d2.tdata;
            if (d1.tvalid && d1.tready) begin got1 = 1; a1 = d1.tdata; q1.push_back(d1.tdata); end
            if (d2.tvalid && d2.tready) begin got2 = 1; a2 = d2.tdata; q2.push_back(d2.tdata); end
            if (s.tvalid && s.tready && s_pend) begin s_pend = 0; nres++; end
            if (got1 && got2) begin
                got1 = 0; got2 = 0; s_pend = 1;
                s_val = {1'b0, a1} + {1'b0, a2} + ((inj_en && (nres == 3 || nres == 7)) ? 9'd1 : 9'd0);
            end
        end
    end

    always @(negedge aclk) begin
        s.tvalid = s_pend || spur;
        s.tdata  = s_pend ? s_val : 9'h1AA;
    end

    // ---------------- wrap-DUT ideal adder ----------------
    logic [DW-1:0] wq1[$], wq2[$];
    logic          w_pend = 0;
    logic [DW:0]   w_val = '0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wq1.delete(); wq2.delete(); w_pend = 0;
        end else begin
            if (start && !w_busy) begin wq1.delete(); wq2.delete(); end
            if (w_s.tvalid && w_s.tready) w_pend = 0;
            if (w_d1.tvalid && w_d1.tready && w_d2.tvalid && w_d2.tready) begin
                wq1.push_back(w_d1.tdata); wq2.push_back(w_d2.tdata);
                w_val = {1'b0, w_d1.tdata} + {1'b0, w_d2.tdata}; w_pend = 1;
            end
        end
    end

    always @(negedge aclk) begin
        w_s.tvalid = w_pend;
        w_s.tdata  = w_val;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic chk_ops(input string tag);
        chk({tag, "_n1"}, q1.size(), N);
        chk({tag, "_n2"}, q2.size(), N);
        for (int k = 0; k < q1.size(); k++) chk({tag, "_op1"}, q1[k], opref(0, S1, k));
        for (int k = 0; k < q2.size(); k++) chk({tag, "_op2"}, q2[k], opref(0, S2, k));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && !done; i++) @(negedge aclk);
        chk({tag, "_done_to"}, done, 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        d1.tready = 0; d2.tready = 0; w_d1.tready = 1; w_d2.tready = 1;
        #2 aresetn = 0;
        repeat (3) @(negedge aclk);
        chk("rst_v1", d1.tvalid, 0);
        chk("rst_v2", d2.tvalid, 0);
        chk("rst_srdy", s.tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_txn", txn_cnt, 0);
        chk("rst_err", err_cnt, 0);
        aresetn = 1;
        @(negedge aclk);

        // ideal loopback: 2 cycles per transaction
        d1.tready = 1; d2.tready = 1;
        pulse_start();
        chk("run1_v1_rise", d1.tvalid, 1);
        repeat (31) @(negedge aclk);
        chk("run1_done_early", done, 0);
        chk("run1_busy", busy, 1);
        @(negedge aclk);
        chk("run1_done", done, 1);
        chk("run1_busy_end", busy, 0);
        chk("run1_txn", txn_cnt, N);
        chk("run1_err", err_cnt, 0);
        chk_ops("run1");

        // carry and wrap instance
        chk("wrap_done", w_done, 1);
        chk("wrap_txn", w_txn, WN);
        chk("wrap_err", w_err, 0);
        chk("wrap_n", wq1.size(), WN);
        for (int k = 0; k < wq1.size(); k++) chk("wrap_op1", wq1[k], opref(WI1, S1, k));
        for (int k = 0; k < wq2.size(); k++) chk("wrap_op2", wq2[k], opref(WI2, S2, k));
        if (wq1.size() > 6) begin
            chk("wrap_sum0", {1'b0, wq1[0]} + {1'b0, wq2[0]}, 9'h104);
            chk("wrap_op1_6", wq1[6], 0);
        end

        // start in DONE with independent backpressure
        d1.tready = 0; d2.tready = 1;
        pulse_start();
        chk("run2_txn_clr", txn_cnt, 0);
        chk("run2_done_clr", done, 0);
        chk("run2_busy", busy, 1);
        repeat (3 + $urandom_range(0, 1)) @(negedge aclk);
        chk("bp_v2_drop", d2.tvalid, 0);
        chk("bp_v1_hold", d1.tvalid, 1);
        chk("bp_d1_data", d1.tdata, opref(0, S1, 0));
        pulse_start();
        chk("busy_start_txn", txn_cnt, 0);
        chk("busy_start_v1", d1.tvalid, 1);
        d1.tready = 1;
        for (int i = 0; i < 50 && txn_cnt != 1; i++) @(negedge aclk);
        chk("run2_txn1_to", txn_cnt, 1);
        d1.tready = 0; d2.tready = 0;
        chk("send2_v1", d1.tvalid, 1);
        chk("send2_v2", d2.tvalid, 1);
        spur = 1;
        repeat (3) @(negedge aclk);
        chk("spur_srdy", s.tready, 0);
        chk("spur_txn", txn_cnt, 1);
        spur = 0; d1.tready = 1; d2.tready = 1;
        @(negedge aclk);
        chk("same_v1", d1.tvalid, 0);
        chk("same_v2", d2.tvalid, 0);
        chk("same_srdy", s.tready, 1);
        wait_done("run2");
        chk("run2_txn", txn_cnt, N);
        chk("run2_err", err_cnt, 0);
        chk_ops("run2");
        chk("stable", stab_bad, 0);

        // error injection on results 3 and 7
        inj_en = 1;
        pulse_start();
        wait_done("run3");
        chk("inj_err", err_cnt, 2);
        chk("inj_txn", txn_cnt, N);
        inj_en = 0;

        // reset during WAIT_SUM of transaction 5
        pulse_start();
        for (int i = 0; i < 100 && !(txn_cnt == 4 && s.tready); i++) @(negedge aclk);
        chk("mid_wait_to", (txn_cnt == 4) && s.tready, 1);
        aresetn = 0;
        #1;
        chk("mid_v1", d1.tvalid, 0);
        chk("mid_v2", d2.tvalid, 0);
        chk("mid_srdy", s.tready, 0);
        chk("mid_txn", txn_cnt, 0);
        chk("mid_busy", busy, 0);
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        pulse_start();
        chk("restart_d1", d1.tdata, 0);
        chk("restart_d2", d2.tdata, 0);
        wait_done("run4");
        chk("run4_txn", txn_cnt, N);
        chk("run4_err", err_cnt, 0);
        chk_ops("run4");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
